wash_controller: RTL and testbench

WASH_CONTROLLER -- requirements
Module: wash_controller

---
 rtl/wash_controller.sv | 136 +++++++++++++
 tb/tb_wash_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/wash_controller.sv
// Wash cycle sequencer: IDLE -> FILL -> WASH -> RINSE (-> WASH ...) -> SPIN -> IDLE.
// Latency: every output is registered. A phase change, with its state_time or wash_done pulse, appears in the cycle after the accepted edge.
// Backpressure: pause=1 holds the current phase and drops timer_finish. coin_in is ignored while busy.
//
// Ports:
//   clk, rst_n    clock (rising edge); asynchronous active-low reset
//   coin_in       start request, level-sampled in IDLE
//   double_wash   double-wash select, captured only when a cycle starts
//   pause         user pause; suspends phase advance and is forwarded to the timer
//   timer_finish  one-cycle pulse: the current phase has elapsed
//   state_time    one-cycle pulse: a new phase has started (restarts the timer)
//   double_time   latched double-wash flag for the timer
//   timer_pause   registered (pause & busy)
//   phase         current phase code
//   busy          phase != IDLE
//   wash_done     one-cycle pulse when SPIN completes
module wash_controller #(
  parameter int DBL_REPEAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_in,
  input  logic       double_wash,
  input  logic       pause,
  input  logic       timer_finish,
  output logic       state_time,
  output logic       double_time,
  output logic       timer_pause,
  output logic [2:0] phase,
  output logic       busy,
  output logic       wash_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    FILL  = 3'b001,
    WASH  = 3'b010,
    RINSE = 3'b011,
    SPIN  = 3'b100
  } phase_t;

  localparam logic [3:0] REP_MAX = 4'(DBL_REPEAT);

  phase_t     state, state_nxt;
  logic [3:0] rep, rep_nxt;
  logic       state_time_nxt;
  logic       wash_done_nxt;
  logic       double_time_nxt;
  logic       timer_pause_nxt;
  logic       advance;

  // A timer_finish that arrives while paused is dropped, not replayed later.
  assign advance = timer_finish && !pause;

  assign phase = state;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rep         <= 4'd0;
      state_time  <= 1'b0;
      wash_done   <= 1'b0;
      double_time <= 1'b0;
      timer_pause <= 1'b0;
    end else begin
      state       <= state_nxt;
      rep         <= rep_nxt;
      state_time  <= state_time_nxt;
      wash_done   <= wash_done_nxt;
      double_time <= double_time_nxt;
      timer_pause <= timer_pause_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    rep_nxt         = rep;
    state_time_nxt  = 1'b0;
    wash_done_nxt   = 1'b0;
    double_time_nxt = double_time;
    timer_pause_nxt = pause && busy;

    case (state)
      IDLE: begin
        // A timer_finish on the same edge as coin_in is ignored. Starting
        // only moves to FILL.
        if (coin_in) begin
          state_nxt       = FILL;
          state_time_nxt  = 1'b1;
          double_time_nxt = double_wash;
          rep_nxt         = 4'd0;
        end
      end
      FILL: begin
        if (advance) begin
          state_nxt      = WASH;
          state_time_nxt = 1'b1;
        end
      end
      WASH: begin
        if (advance) begin
          state_nxt      = RINSE;
          state_time_nxt = 1'b1;
        end
      end
      RINSE: begin
        if (advance) begin
          state_time_nxt = 1'b1;
          // rep only increments while below REP_MAX, so it saturates and
          // never wraps.
          if (double_time && (rep < REP_MAX)) begin
            state_nxt = WASH;
            rep_nxt   = rep + 4'd1;
          end else begin
            state_nxt = SPIN;
          end
        end
      end
      SPIN: begin
        if (advance) begin
          state_nxt       = IDLE;
          wash_done_nxt   = 1'b1;
          double_time_nxt = 1'b0;
        end
      end
      default: begin
        // Unused codes recover to IDLE with every pulse held low.
        state_nxt       = IDLE;
        double_time_nxt = 1'b0;
        rep_nxt         = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_wash_controller.sv
module tb_wash_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_in = 1'b0;
  logic       double_wash = 1'b0;
  logic       pause = 1'b0;
  logic       timer_finish = 1'b0;
  logic       state_time;
  logic       double_time;
  logic       timer_pause;
  logic [2:0] phase;
  logic       busy;
  logic       wash_done;

  wash_controller #(.DBL_REPEAT(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .coin_in      (coin_in),
    .double_wash  (double_wash),
    .pause        (pause),
    .timer_finish (timer_finish),
    .state_time   (state_time),
    .double_time  (double_time),
    .timer_pause  (timer_pause),
    .phase        (phase),
    .busy         (busy),
    .wash_done    (wash_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int st_cnt = 0;
  int done_cnt = 0;
  int st_base;
  int done_base;

  // Pulse counters, sampled on the falling edge.
  always @(negedge clk) begin
    if (state_time === 1'b1) st_cnt++;
    if (wash_done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fin();
    timer_finish = 1'b1;
    step(1);
    timer_finish = 1'b0;
  endtask

  task automatic start_cycle(input logic dw);
    double_wash = dw;
    coin_in = 1'b1;
    step(1);
    coin_in = 1'b0;
  endtask

  int single_seq [4] = '{2, 3, 4, 0};
  int double_seq [6] = '{2, 3, 2, 3, 4, 0};

  initial begin
    // Reset state
    step(3);
    check("rst_phase", phase, 0);
    check("rst_busy", busy, 0);
    check("rst_state_time", state_time, 0);
    check("rst_double_time", double_time, 0);
    check("rst_timer_pause", timer_pause, 0);
    check("rst_wash_done", wash_done, 0);
    rst_n = 1'b1;
    step(2);

    // Single wash
    st_base = st_cnt; done_base = done_cnt;
    start_cycle(1'b0);
    check("single_start_phase", phase, 1);
    check("single_start_st", state_time, 1);
    check("single_start_busy", busy, 1);
    check("single_start_dbl", double_time, 0);
    step(1);
    check("single_st_one_cycle", state_time, 0);
    for (int i = 0; i < 4; i++) begin
      step(8);
      fin();
      check($sformatf("single_phase_%0d", i), phase, single_seq[i]);
      if (i == 3) begin
        check("single_done_pulse", wash_done, 1);
        check("single_done_busy", busy, 0);
        check("single_done_st", state_time, 0);
      end else begin
        check($sformatf("single_st_%0d", i), state_time, 1);
      end
    end
    step(1);
    check("single_done_one_cycle", wash_done, 0);
    step(2);
    check("single_st_count", st_cnt - st_base, 4);
    check("single_done_count", done_cnt - done_base, 1);

    // Double wash; double_wash drops after start and must not matter
    st_base = st_cnt; done_base = done_cnt;
    start_cycle(1'b1);
    double_wash = 1'b0;
    check("dbl_start_phase", phase, 1);
    check("dbl_latched", double_time, 1);
    for (int i = 0; i < 6; i++) begin
      step(9);
      fin();
      check($sformatf("dbl_phase_%0d", i), phase, double_seq[i]);
      check($sformatf("dbl_flag_%0d", i), double_time, (i == 5) ? 0 : 1);
    end
    step(3);
    check("dbl_st_count", st_cnt - st_base, 6);
    check("dbl_done_count", done_cnt - done_base, 1);

    // Idle: pause is not forwarded and timer_finish is ignored
    st_base = st_cnt;
    pause = 1'b1;
    step(2);
    check("idle_timer_pause", timer_pause, 0);
    pause = 1'b0;
    fin();
    check("idle_finish_phase", phase, 0);
    step(2);
    check("idle_finish_no_st", st_cnt - st_base, 0);

    // Pause during WASH; double_wash raised mid-cycle is ignored
    start_cycle(1'b0);
    double_wash = 1'b1;
    step(3);
    fin();
    check("pause_in_wash", phase, 2);
    step(2);
    pause = 1'b1;
    step(1);
    check("pause_forwarded", timer_pause, 1);
    fin();
    check("pause_drop_phase", phase, 2);
    check("pause_drop_st", state_time, 0);
    pause = 1'b0;
    step(1);
    check("pause_release", timer_pause, 0);
    step(3);
    check("pause_no_replay", phase, 2);
    fin();
    check("pause_resume_phase", phase, 3);
    check("mid_dw_ignored", double_time, 0);
    step(2);
    st_base = st_cnt;
    coin_in = 1'b1;
    step(1);
    coin_in = 1'b0;
    check("coin_busy_phase", phase, 3);
    step(2);
    check("coin_busy_no_st", st_cnt - st_base, 0);
    fin();
    check("no_repeat_spin", phase, 4);
    double_wash = 1'b0;
    step(2);

    // Reset mid SPIN: outputs clear at once and no wash_done is issued
    done_base = done_cnt;
    check("reset_pre_spin", phase, 4);
    #2 rst_n = 1'b0;
    #1;
    check("async_phase", phase, 0);
    check("async_busy", busy, 0);
    check("async_state_time", state_time, 0);
    check("async_wash_done", wash_done, 0);
    check("async_timer_pause", timer_pause, 0);
    timer_finish = 1'b1;
    step(2);
    timer_finish = 1'b0;
    rst_n = 1'b1;
    step(2);
    check("reset_no_done", done_cnt - done_base, 0);
    start_cycle(1'b0);
    check("post_reset_phase", phase, 1);
    check("post_reset_st", state_time, 1);

    // coin_in and timer_finish together in IDLE
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
    coin_in = 1'b1;
    timer_finish = 1'b1;
    step(1);
    coin_in = 1'b0;
    timer_finish = 1'b0;
    check("simul_phase", phase, 1);
    check("simul_st", state_time, 1);
    step(2);
    check("simul_hold", phase, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
